// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I pipeline control logic.
package riscv_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned TO_W  = 16;
  localparam logic [REG_W-1:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FAULT = 2'd2
  } mem_state_t;

  // Operand source for one execute-stage operand; M is younger, so it wins over W.
  function automatic fwd_sel_t fwd_sel(input logic [REG_W-1:0] rs,
                                       input logic [REG_W-1:0] rd_m,
                                       input logic [REG_W-1:0] rd_w,
                                       input logic             we_m,
                                       input logic             we_w);
    if (we_m && (rd_m != REG_X0) && (rd_m == rs))
      return FWD_M;
    else if (we_w && (rd_w != REG_X0) && (rd_w == rs))
      return FWD_W;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Data-memory handshake between the M stage, the control unit and data memory.
interface hazard_ctrl_if;
  logic mem_op_m;
  logic dmem_ack;
  logic dmem_req;

  modport master (input mem_op_m, input dmem_ack, output dmem_req);
  modport slave  (output mem_op_m, output dmem_ack, input dmem_req);
endinterface

// File: rtl/hazard_ctrl_dmem_wait_fsm.sv
// Data-memory request/ack sequencer with a timeout watchdog that latches a fault.
module dmem_wait_fsm
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_op_m,
  input  logic dmem_ack,
  output logic dmem_req,
  output logic mem_stall,
  output logic mem_fault
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  mem_state_t      state_q;
  logic [TO_W-1:0] cnt_q;

  // State and timeout counter; FAULT is left only through reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op_m && !dmem_ack) begin
            state_q <= BUSY;
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          if (dmem_ack)
            state_q <= IDLE;
          else if (cnt_q == TO_LAST)
            state_q <= FAULT;
          else
            cnt_q <= cnt_q + TO_W'(1);
        end
        FAULT:   state_q <= FAULT;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The ack cycle itself never stalls, so M advances on the completing edge.
  always_comb begin
    dmem_req  = 1'b0;
    mem_stall = 1'b0;
    mem_fault = 1'b0;
    case (state_q)
      IDLE: begin
        dmem_req  = mem_op_m;
        mem_stall = mem_op_m && !dmem_ack;
      end
      BUSY: begin
        dmem_req  = 1'b1;
        mem_stall = !dmem_ack;
      end
      FAULT: begin
        mem_stall = 1'b1;
        mem_fault = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      dmem_req  = 1'b0;
      mem_stall = 1'b0;
      mem_fault = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline control: forwarding, load-use/branch hazards, memory-wait stalls.
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [REG_W-1:0]   rs1_d,
  input  logic [REG_W-1:0]   rs2_d,
  input  logic [REG_W-1:0]   rs1_e,
  input  logic [REG_W-1:0]   rs2_e,
  input  logic [REG_W-1:0]   rd_e,
  input  logic               load_e,
  input  logic [REG_W-1:0]   rd_m,
  input  logic [REG_W-1:0]   rd_w,
  input  logic               reg_write_m,
  input  logic               reg_write_w,
  input  logic               pc_src_e,
  hazard_ctrl_if.master      mem_bus,
  output logic [1:0]         forward_a_e,
  output logic [1:0]         forward_b_e,
  output logic               stall_f,
  output logic               stall_d,
  output logic               stall_e,
  output logic               stall_m,
  output logic               flush_d,
  output logic               flush_e,
  output logic               flush_w,
  output logic               mem_fault,
  output logic [CNT_W-1:0]   stall_cnt
);

  logic             mem_stall;
  logic             lw_stall;
  logic             lw_eff;
  logic [CNT_W-1:0] stall_cnt_q;

  dmem_wait_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_dmem_wait (
    .clk       (clk),
    .reset     (reset),
    .mem_op_m  (mem_bus.mem_op_m),
    .dmem_ack  (mem_bus.dmem_ack),
    .dmem_req  (mem_bus.dmem_req),
    .mem_stall (mem_stall),
    .mem_fault (mem_fault)
  );

  always_comb begin
    forward_a_e = 2'(fwd_sel(rs1_e, rd_m, rd_w, reg_write_m, reg_write_w));
    forward_b_e = 2'(fwd_sel(rs2_e, rd_m, rd_w, reg_write_m, reg_write_w));
  end

  assign lw_stall = load_e && (rd_e != REG_X0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  // A taken branch squashes the load-use consumer anyway, so it overrides lw_stall.
  assign lw_eff = lw_stall && !pc_src_e;

  // A memory wait freezes everything; D/E hazards are re-evaluated after release.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (reset) begin
      stall_f = 1'b0;
    end else if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else begin
      stall_f = lw_eff;
      stall_d = lw_eff;
      flush_d = pc_src_e;
      flush_e = pc_src_e || lw_eff;
    end
  end

  // Saturating count of front-end stall cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt_q <= '0;
    else if (stall_f && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed vectors for hazard_ctrl; expectations queued by stimulus, checked by a monitor.
module tb_hazard_ctrl;
  import riscv_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       load_e, reg_write_m, reg_write_w, pc_src_e;
  logic [1:0] forward_a_e, forward_b_e;
  logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_fault;
  logic [31:0] stall_cnt;

  hazard_ctrl_if mem_bus();

  hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .load_e(load_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .pc_src_e(pc_src_e),
    .mem_bus(mem_bus),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .mem_fault(mem_fault), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Expected bits: {fa[1:0], fb[1:0], sf, sd, se, sm, fd, fe, fw, dmem_req, mem_fault}
  typedef struct {
    logic [12:0] o;
    logic [31:0] cnt;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [12:0] ZERO   = 13'b00_00_0000_000_00;
  localparam logic [12:0] MSTALL = 13'b00_00_1111_001_10;
  localparam logic [12:0] MFAULT = 13'b00_00_1111_001_01;
  localparam logic [12:0] REQ    = 13'b00_00_0000_000_10;

  task automatic clr();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    load_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0; pc_src_e = 1'b0;
    mem_bus.mem_op_m = 1'b0; mem_bus.dmem_ack = 1'b0;
  endtask

  task automatic vec(input logic [12:0] o, input logic [31:0] cnt, input string nm);
    exp_t e;
    e.o = o; e.cnt = cnt; e.name = nm;
    sb.push_back(e);
    @(posedge clk) #1;
  endtask

  // Monitor: outputs are combinational, so each cycle's vector is checked mid-cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      logic [12:0] act;
      e = sb.pop_front();
      act = {forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
             flush_d, flush_e, flush_w, mem_bus.dmem_req, mem_fault};
      checks++;
      if (act !== e.o || stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL %s: got %b cnt %0d, want %b cnt %0d", e.name, act, stall_cnt, e.o, e.cnt);
      end
    end
  end

  initial begin
    reset = 1'b1;
    clr();
    @(posedge clk) #1;

    load_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7; mem_bus.mem_op_m = 1'b1;
    vec(ZERO, 0, "reset_outputs");
    reset = 1'b0; clr();
    vec(ZERO, 0, "idle");

    rd_m = 5'd5; rd_w = 5'd5; reg_write_m = 1'b1; reg_write_w = 1'b1; rs1_e = 5'd5;
    vec(13'b10_00_0000_000_00, 0, "fwd_m_priority");
    reg_write_m = 1'b0;
    vec(13'b01_00_0000_000_00, 0, "fwd_w");
    reg_write_m = 1'b1; rd_m = 5'd6; rs1_e = 5'd6; rs2_e = 5'd5;
    vec(13'b10_01_0000_000_00, 0, "fwd_a_m_b_w");
    rd_m = 5'd0; rd_w = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0;
    vec(ZERO, 0, "fwd_x0");

    clr(); load_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
    vec(13'b00_00_1100_010_00, 0, "load_use");
    clr();
    vec(ZERO, 1, "load_use_release");
    load_e = 1'b1; rd_e = 5'd0; rs1_d = 5'd0;
    vec(ZERO, 1, "load_x0_no_stall");

    clr(); pc_src_e = 1'b1;
    vec(13'b00_00_0000_110_00, 1, "branch");
    load_e = 1'b1; rd_e = 5'd7; rs1_d = 5'd7;
    vec(13'b00_00_0000_110_00, 1, "branch_over_load_use");
    clr();
    vec(ZERO, 1, "quiet");

    mem_bus.mem_op_m = 1'b1;
    vec(MSTALL, 1, "mem_wait0");
    vec(MSTALL, 2, "mem_wait1");
    vec(MSTALL, 3, "mem_wait2");
    mem_bus.dmem_ack = 1'b1;
    vec(REQ, 4, "mem_ack");
    clr();
    vec(ZERO, 4, "mem_done");

    mem_bus.mem_op_m = 1'b1; mem_bus.dmem_ack = 1'b1;
    vec(REQ, 4, "mem_zero_wait");
    mem_bus.mem_op_m = 1'b0;
    vec(ZERO, 4, "stray_ack");

    clr(); mem_bus.mem_op_m = 1'b1; pc_src_e = 1'b1;
    vec(MSTALL, 4, "mem_branch0");
    vec(MSTALL, 5, "mem_branch1");
    mem_bus.dmem_ack = 1'b1;
    vec(13'b00_00_0000_110_10, 6, "mem_branch_release");
    clr();
    vec(ZERO, 6, "quiet2");

    mem_bus.mem_op_m = 1'b1;
    vec(MSTALL, 6, "to_idle");
    vec(MSTALL, 7, "to_busy0");
    vec(MSTALL, 8, "to_busy1");
    vec(MSTALL, 9, "to_busy2");
    vec(MSTALL, 10, "to_busy3");
    vec(MFAULT, 11, "fault");
    pc_src_e = 1'b1; mem_bus.dmem_ack = 1'b1;
    vec(MFAULT, 12, "fault_sticky");

    pc_src_e = 1'b0; mem_bus.dmem_ack = 1'b0;
    reset = 1'b1;
    vec(ZERO, 0, "reset_in_fault");
    reset = 1'b0;
    vec(MSTALL, 0, "post_reset_idle");
    mem_bus.dmem_ack = 1'b1;
    vec(REQ, 1, "post_reset_ack");
    clr();
    vec(ZERO, 1, "final_idle");

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline control unit for the five-stage RV32I core. It steers the per-stage pipeline registers (F/D, D/E, E/M, M/W) via stall and flush, selects operand forwarding for the execute stage, and sequences the data-memory request/acknowledge handshake with a timeout watchdog. It sits beside the datapath and drives the enable and clear inputs of every inter-stage register.

## Interface
- TIMEOUT_CYCLES, 255: maximum BUSY cycles before a memory fault (1..65535).
- CNT_W, 32: width of the stall performance counter.

Ports (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- rs1_d, rs2_d  in  5  source registers in decode
- rs1_e, rs2_e, rd_e  in  5  source and destination registers in execute
- load_e  in  1  instruction in E is a load (result from memory)
- rd_m, rd_w  in  5  destination registers in M and W
- reg_write_m, reg_write_w  in  1  M/W instruction writes the register file
- pc_src_e  in  1  taken branch or jump resolved in E
- mem_op_m  in  1  load or store present in M
- dmem_ack  in  1  single-cycle completion pulse from data memory
- dmem_req  out  1  data-memory request, held until ack
- forward_a_e, forward_b_e  out  2  operand select: 00 register file, 10 M result, 01 W result
- stall_f, stall_d, stall_e, stall_m  out  1  hold the corresponding stage register
- flush_d, flush_e, flush_w  out  1  clear the register into D, E, W to a bubble
- mem_fault  out  1  sticky; memory timed out
- stall_cnt  out  CNT_W  saturating count of cycles with stall_f=1

## Operation
- **Forwarding (combinational):**
  - forward_a_e=10 if reg_write_m && rd_m!=0 && rd_m==rs1_e.
  - Else 01 if reg_write_w && rd_w!=0 && rd_w==rs1_e.
  - Else 00. The same rule applies to forward_b_e with rs2_e.
  - M has priority over W. x0 is never forwarded.
- **Load-use hazard:** lw_stall = load_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d). It produces stall_f=stall_d=1 and flush_e=1.
- **Control hazard:** pc_src_e produces flush_d=1 and flush_e=1. lw_stall and pc_src_e cannot both be true, because both the load and the branch would have to be in E. If both are asserted, pc_src_e wins and lw_stall is ignored.
- **Memory FSM** (states IDLE, BUSY, FAULT):
  - IDLE:
    - dmem_req=mem_op_m.
    - If mem_op_m && !dmem_ack, go to BUSY and load the timeout counter with 0.
    - If mem_op_m && dmem_ack, complete with zero wait.
  - BUSY:
    - dmem_req=1 and mem_stall=1.
    - On dmem_ack, go to IDLE. mem_stall is 0 in the ack cycle, so M advances.
    - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 without ack, go to FAULT.
  - FAULT:
    - dmem_req=0, mem_stall=1, mem_fault=1.
    - Exit only by reset.
- **mem_stall dominates:**
  - stall_f/d/e/m=1 and flush_w=1 (bubble into W).
  - flush_d and flush_e are forced to 0; lw_stall and pc_src_e are re-evaluated once the stall releases.
- **stall_cnt** increments on every cycle with stall_f=1 and saturates at all-ones.

## Timing
- Reset (async) gives: FSM=IDLE, timeout counter=0, mem_fault=0, stall_cnt=0. While reset is high, dmem_req=0 and all stall and flush outputs are 0.
- Forwarding, stall and flush outputs are combinational from the inputs and current state, valid in the same cycle. They are registered downstream by the pipeline registers.
- Memory handshake latency:
  - Zero-wait ack: 0 stall cycles.
  - Ack N cycles after the request: N stall cycles.
  - FAULT is entered at the edge after TIMEOUT_CYCLES BUSY cycles with no ack.
- A dmem_ack that arrives while in IDLE with mem_op_m=0 is ignored.
- Reset during BUSY or FAULT returns to IDLE immediately. The aborted request is dropped and dmem_req deasserts asynchronously.

## Structure
- riscv_pkg holds:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10)
  - mem_state_t enum (IDLE, BUSY, FAULT)
  - REG_X0 constant
- One sub-module: dmem_wait_fsm, containing the FSM, timeout counter, dmem_req, mem_stall and mem_fault.
- Forwarding, hazard-combining logic and stall_cnt stay in hazard_ctrl.

## Test plan
- **Forwarding:**
  - rd_m=5 and rd_w=5, both with write enabled, and rs1_e=5: forward_a_e=10.
  - Clear reg_write_m: forward_a_e=01.
  - rd_m=0 with rs1_e=0: forward_a_e=00.
- **Load-use:** load_e=1, rd_e=7, rs2_d=7 → stall_f=stall_d=flush_e=1 for exactly one cycle; stall_cnt increments by 1.
- **Branch:** pc_src_e=1 → flush_d=flush_e=1, no stalls.
- **Memory wait:** mem_op_m=1, ack 3 cycles later → dmem_req high 4 cycles; stall_m and flush_w high 3 cycles, low in the ack cycle.
- **Memory wait with branch:** pc_src_e=1 during the memory wait → flush_d=flush_e=0 until release, then 1.
- **Timeout:** TIMEOUT_CYCLES=4, no ack → FAULT after 4 BUSY cycles; mem_fault=1, stalls held, dmem_req=0. Assert reset mid-FAULT → all outputs 0, FSM=IDLE.
